// File: rtl/rram_ctrl_pkg.sv
// Shared types and timing constants for the RRAM operation sequencer.
// Ops, FSM states, bias one-hots and the op -> line-bias lookup.
package rram_ctrl_pkg;

    localparam int PRE_CYC   = 2;
    localparam int BIAS_CYC  = 4;
    localparam int SA_CYC    = 2;
    localparam int ADC_CYC   = 3;
    localparam int PULSE_CYC = 8;
    localparam int TW        = 4;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_SET   = 2'd1,
        OP_RESET = 2'd2,
        OP_FORM  = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_PRECH,
        S_BIAS,
        S_SENSE,
        S_CONV,
        S_PULSE,
        S_DISCH,
        S_RESP
    } state_e;

    localparam logic [3:0] V1 = 4'b0001;
    localparam logic [3:0] V2 = 4'b0010;
    localparam logic [3:0] V3 = 4'b0100;
    localparam logic [3:0] V4 = 4'b1000;

    typedef struct packed {
        logic [3:0] vwl;
        logic [3:0] vbl;
        logic [3:0] vsl;
    } bias_t;

    function automatic bias_t bias_sel(input op_e op);
        bias_t b;
        b = '0;
        case (op)
            OP_READ:  b = {V1, V1, V4};
            OP_SET:   b = {V2, V3, V4};
            OP_RESET: b = {V2, V4, V3};
            OP_FORM:  b = {V3, V2, V4};
            default:  b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rram_phase_timer.sv
// Loadable down-counter timing each sequencer phase.
// done_o is high once the count has reached zero.
module rram_phase_timer
    import rram_ctrl_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [TW-1:0] val_i,
    output logic          done_o
);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/rram_op_sequencer.sv
// Single-operation sequencer for the 16x16 RRAM macro: line drivers,
// CSA/ADC control and result capture behind a request/response handshake.
module rram_op_sequencer
    import rram_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [1:0]  REQ_OP,
    input  logic [3:0]  REQ_ROW,
    input  logic [15:0] REQ_COL_MASK,
    input  logic        REQ_REF_CSA,
    input  logic        ABORT,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic        RSP_ERR,
    output logic [15:0] RSP_CSA,
    output logic [47:0] RSP_ADC,
    output logic        ENABLE_WL,
    output logic        ENABLE_BL,
    output logic        ENABLE_SL,
    output logic [3:0]  V_WL,
    output logic [3:0]  V_BL,
    output logic [3:0]  V_SL,
    output logic [15:0] IN1_WL,
    output logic [15:0] IN1_BL,
    output logic [15:0] IN1_SL,
    output logic [15:0] IN0_WL,
    output logic [15:0] IN0_BL,
    output logic [15:0] IN0_SL,
    output logic        PRE,
    output logic        ENABLE_CSA,
    output logic        SAEN_CSA,
    output logic        REF_CSA,
    output logic [1:0]  CLK_EN_ADC,
    input  logic [15:0] CSA,
    input  logic [15:0] ADC_OUT0,
    input  logic [15:0] ADC_OUT1,
    input  logic [15:0] ADC_OUT2
);

    state_e        state_q, state_d;
    op_e           op_q;
    logic [15:0]   mask_q;
    logic          ref_q;
    logic          err_q;
    logic [15:0]   csa_q;
    logic [47:0]   adc_q;
    logic          accept;
    logic          abortable;
    logic          tmr_load;
    logic          tmr_done;
    logic [TW-1:0] tmr_val;
    bias_t         req_bias;
    logic [15:0]   req_wl;
    logic [15:0]   req_cols;

    assign REQ_READY = (state_q == S_IDLE);
    assign accept    = REQ_VALID && REQ_READY;
    assign abortable = state_q inside {S_SETUP, S_PRECH, S_BIAS,
                                       S_SENSE, S_CONV, S_PULSE};
    assign req_bias  = bias_sel(op_e'(REQ_OP));
    assign req_wl    = 16'(1) << REQ_ROW;
    assign req_cols  = (op_e'(REQ_OP) == OP_READ) ? 16'hFFFF : REQ_COL_MASK;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (REQ_VALID) state_d = S_SETUP;
            S_SETUP: begin
                if (op_q == OP_READ)    state_d = S_PRECH;
                else if (mask_q == '0)  state_d = S_DISCH;
                else                    state_d = S_PULSE;
            end
            S_PRECH: if (tmr_done) state_d = S_BIAS;
            S_BIAS:  if (tmr_done) state_d = S_SENSE;
            S_SENSE: if (tmr_done) state_d = S_CONV;
            S_CONV:  if (tmr_done) state_d = S_DISCH;
            S_PULSE: if (tmr_done) state_d = S_DISCH;
            S_DISCH: state_d = S_RESP;
            S_RESP:  if (RSP_READY) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides any phase exit, including the last cycle.
        if (ABORT && abortable) state_d = S_DISCH;
    end

    always_comb begin
        tmr_load = (state_d != state_q);
        case (state_d)
            S_PRECH: tmr_val = TW'(PRE_CYC - 1);
            S_BIAS:  tmr_val = TW'(BIAS_CYC - 1);
            S_SENSE: tmr_val = TW'(SA_CYC - 1);
            S_CONV:  tmr_val = TW'(ADC_CYC - 1);
            S_PULSE: tmr_val = TW'(PULSE_CYC - 1);
            default: tmr_val = '0;
        endcase
    end

    rram_phase_timer u_timer (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .done_o (tmr_done)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            op_q       <= OP_READ;
            mask_q     <= '0;
            ref_q      <= 1'b0;
            err_q      <= 1'b0;
            csa_q      <= '0;
            adc_q      <= '0;
            RSP_VALID  <= 1'b0;
            RSP_ERR    <= 1'b0;
            RSP_CSA    <= '0;
            RSP_ADC    <= '0;
            ENABLE_WL  <= 1'b0;
            ENABLE_BL  <= 1'b0;
            ENABLE_SL  <= 1'b0;
            V_WL       <= '0;
            V_BL       <= '0;
            V_SL       <= '0;
            IN1_WL     <= '0;
            IN1_BL     <= '0;
            IN1_SL     <= '0;
            IN0_WL     <= '0;
            IN0_BL     <= '0;
            IN0_SL     <= '0;
            PRE        <= 1'b0;
            ENABLE_CSA <= 1'b0;
            SAEN_CSA   <= 1'b0;
            REF_CSA    <= 1'b0;
            CLK_EN_ADC <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= op_e'(REQ_OP);
                mask_q <= REQ_COL_MASK;
                ref_q  <= REQ_REF_CSA;
                err_q  <= 1'b0;
                csa_q  <= '0;
                adc_q  <= '0;
                V_WL   <= req_bias.vwl;
                V_BL   <= req_bias.vbl;
                V_SL   <= req_bias.vsl;
                IN1_WL <= req_wl;
                IN0_WL <= ~req_wl;
                IN1_BL <= req_cols;
                IN0_BL <= ~req_cols;
                IN1_SL <= req_cols;
                IN0_SL <= ~req_cols;
            end else if (state_d == S_RESP) begin
                V_WL   <= '0;
                V_BL   <= '0;
                V_SL   <= '0;
                IN1_WL <= '0;
                IN1_BL <= '0;
                IN1_SL <= '0;
                IN0_WL <= '0;
                IN0_BL <= '0;
                IN0_SL <= '0;
            end
            if (state_q == S_SETUP && op_q != OP_READ && mask_q == '0)
                err_q <= 1'b1;
            if (ABORT && abortable)
                err_q <= 1'b1;
            if (state_q == S_SENSE && state_d == S_CONV)
                csa_q <= CSA;
            if (state_q == S_CONV && state_d == S_DISCH && !ABORT)
                adc_q <= {ADC_OUT2, ADC_OUT1, ADC_OUT0};
            ENABLE_WL  <= state_d inside {S_BIAS, S_SENSE, S_CONV, S_PULSE};
            ENABLE_BL  <= state_d inside {S_BIAS, S_SENSE, S_CONV, S_PULSE};
            ENABLE_SL  <= state_d inside {S_BIAS, S_SENSE, S_CONV, S_PULSE};
            PRE        <= (state_d == S_PRECH);
            ENABLE_CSA <= (state_d == S_SENSE);
            SAEN_CSA   <= (state_d == S_SENSE);
            REF_CSA    <= (state_d == S_SENSE) && ref_q;
            CLK_EN_ADC <= {2{state_d == S_CONV}};
            if (state_q != S_RESP && state_d == S_RESP) begin
                RSP_VALID <= 1'b1;
                RSP_ERR   <= err_q;
                RSP_CSA   <= err_q ? 16'h0 : csa_q;
                RSP_ADC   <= err_q ? 48'h0 : adc_q;
            end else if (state_q == S_RESP && RSP_READY) begin
                RSP_VALID <= 1'b0;
                RSP_ERR   <= 1'b0;
                RSP_CSA   <= '0;
                RSP_ADC   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rram_op_sequencer.sv
// Scoreboard bench for rram_op_sequencer: per-scenario tasks with inline checks.
module tb_rram_op_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [1:0]  REQ_OP = '0;
    logic [3:0]  REQ_ROW = '0;
    logic [15:0] REQ_COL_MASK = '0;
    logic        REQ_REF_CSA = 1'b0;
    logic        ABORT = 1'b0;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b0;
    logic        RSP_ERR;
    logic [15:0] RSP_CSA;
    logic [47:0] RSP_ADC;
    logic        ENABLE_WL, ENABLE_BL, ENABLE_SL;
    logic [3:0]  V_WL, V_BL, V_SL;
    logic [15:0] IN1_WL, IN1_BL, IN1_SL;
    logic [15:0] IN0_WL, IN0_BL, IN0_SL;
    logic        PRE, ENABLE_CSA, SAEN_CSA, REF_CSA;
    logic [1:0]  CLK_EN_ADC;
    logic [15:0] CSA = '0;
    logic [15:0] ADC_OUT0 = '0;
    logic [15:0] ADC_OUT1 = '0;
    logic [15:0] ADC_OUT2 = '0;

    always #5 CLK = ~CLK;

    rram_op_sequencer dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OP(REQ_OP), .REQ_ROW(REQ_ROW),
        .REQ_COL_MASK(REQ_COL_MASK), .REQ_REF_CSA(REQ_REF_CSA),
        .ABORT(ABORT),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_ERR(RSP_ERR), .RSP_CSA(RSP_CSA), .RSP_ADC(RSP_ADC),
        .ENABLE_WL(ENABLE_WL), .ENABLE_BL(ENABLE_BL), .ENABLE_SL(ENABLE_SL),
        .V_WL(V_WL), .V_BL(V_BL), .V_SL(V_SL),
        .IN1_WL(IN1_WL), .IN1_BL(IN1_BL), .IN1_SL(IN1_SL),
        .IN0_WL(IN0_WL), .IN0_BL(IN0_BL), .IN0_SL(IN0_SL),
        .PRE(PRE), .ENABLE_CSA(ENABLE_CSA), .SAEN_CSA(SAEN_CSA),
        .REF_CSA(REF_CSA), .CLK_EN_ADC(CLK_EN_ADC),
        .CSA(CSA), .ADC_OUT0(ADC_OUT0), .ADC_OUT1(ADC_OUT1),
        .ADC_OUT2(ADC_OUT2)
    );

    typedef struct {
        logic        err;
        logic [15:0] csa;
        logic [47:0] adc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int lat;
    int wait_edges;
    logic [3:0]  s_vwl, s_vbl, s_vsl;
    logic [15:0] s_in1wl, s_in0wl, s_in1bl, s_in1sl;
    logic [63:0] tr_pre, tr_saen, tr_en, tr_adc, tr_ref, tr_any;

    function automatic logic outs_nonzero();
        return |{ENABLE_WL, ENABLE_BL, ENABLE_SL, V_WL, V_BL, V_SL,
                 IN1_WL, IN1_BL, IN1_SL, IN0_WL, IN0_BL, IN0_SL,
                 PRE, ENABLE_CSA, SAEN_CSA, REF_CSA, CLK_EN_ADC,
                 RSP_VALID, RSP_ERR, RSP_CSA, RSP_ADC};
    endfunction

    // Issue one request, push its expected response, trace until RSP_VALID.
    task automatic run_op(input logic [1:0] op, input logic [3:0] row,
                          input logic [15:0] mask, input logic rf,
                          input int abort_at, input exp_t e);
        logic rdy;
        logic acc;
        sb.push_back(e);
        REQ_OP = op;
        REQ_ROW = row;
        REQ_COL_MASK = mask;
        REQ_REF_CSA = rf;
        REQ_VALID = 1'b1;
        wait_edges = 0;
        acc = 1'b0;
        lat = -1;
        {tr_pre, tr_saen, tr_en, tr_adc, tr_ref, tr_any} = '0;
        while (!acc && wait_edges < 10) begin
            rdy = REQ_READY;
            @(posedge CLK);
            wait_edges++;
            acc = rdy;
            @(negedge CLK);
            RSP_READY = 1'b0;
        end
        REQ_VALID = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout edges=%0d", wait_edges);
        end
        for (int k = 1; k <= 40; k++) begin
            if (k == 1) begin
                s_vwl = V_WL;
                s_vbl = V_BL;
                s_vsl = V_SL;
                s_in1wl = IN1_WL;
                s_in0wl = IN0_WL;
                s_in1bl = IN1_BL;
                s_in1sl = IN1_SL;
            end
            tr_pre[k]  = PRE;
            tr_saen[k] = SAEN_CSA;
            tr_en[k]   = ENABLE_WL & ENABLE_BL & ENABLE_SL;
            tr_adc[k]  = &CLK_EN_ADC;
            tr_ref[k]  = REF_CSA;
            tr_any[k]  = |{ENABLE_WL, ENABLE_BL, ENABLE_SL, PRE,
                           ENABLE_CSA, SAEN_CSA, CLK_EN_ADC};
            if (RSP_VALID) begin
                lat = k - 1;
                break;
            end
            ABORT = (k == abort_at);
            @(negedge CLK);
        end
        ABORT = 1'b0;
    endtask

    task automatic ack();
        RSP_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RSP_READY = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (outs_nonzero() !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", outs_nonzero());
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (REQ_READY !== 1'b1) begin
            failures++;
            $display("FAIL reset_req_ready got=%b exp=1", REQ_READY);
        end
    endtask

    task automatic test_read();
        exp_t e, g;
        CSA = 16'hA5A5;
        ADC_OUT0 = 16'd1;
        ADC_OUT1 = 16'd2;
        ADC_OUT2 = 16'd3;
        e = '{err: 1'b0, csa: 16'hA5A5, adc: 48'h0003_0002_0001};
        run_op(2'd0, 4'd5, 16'h1234, 1'b1, 0, e);
        checks++;
        if (lat !== 13) begin
            failures++;
            $display("FAIL read_latency got=%0d exp=13", lat);
        end
        checks++;
        if ({s_in1wl, s_in0wl, s_in1bl} !== {16'h0020, 16'hFFDF, 16'hFFFF}) begin
            failures++;
            $display("FAIL read_lines got=%h/%h/%h exp=0020/ffdf/ffff",
                     s_in1wl, s_in0wl, s_in1bl);
        end
        checks++;
        if ({s_vwl, s_vbl, s_vsl} !== {4'b0001, 4'b0001, 4'b1000}) begin
            failures++;
            $display("FAIL read_bias got=%b/%b/%b exp=0001/0001/1000",
                     s_vwl, s_vbl, s_vsl);
        end
        checks++;
        if (tr_pre !== 64'h000C || tr_saen !== 64'h0300) begin
            failures++;
            $display("FAIL read_pre_saen got=%h/%h exp=c/300", tr_pre, tr_saen);
        end
        checks++;
        if (tr_en !== 64'h1FF0 || tr_adc !== 64'h1C00 || tr_ref !== 64'h0300) begin
            failures++;
            $display("FAIL read_en_adc_ref got=%h/%h/%h exp=1ff0/1c00/300",
                     tr_en, tr_adc, tr_ref);
        end
        g = sb.pop_front();
        checks++;
        if ({RSP_ERR, RSP_CSA, RSP_ADC} !== {g.err, g.csa, g.adc}) begin
            failures++;
            $display("FAIL read_rsp got=%b/%h/%h exp=%b/%h/%h",
                     RSP_ERR, RSP_CSA, RSP_ADC, g.err, g.csa, g.adc);
        end
        ack();
        checks++;
        if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) begin
            failures++;
            $display("FAIL read_handshake got=%b/%b exp=0/1", RSP_VALID, REQ_READY);
        end
    endtask

    task automatic test_reset_op();
        exp_t e, g;
        e = '{err: 1'b0, csa: 16'h0, adc: 48'h0};
        run_op(2'd2, 4'd0, 16'h00F0, 1'b0, 0, e);
        checks++;
        if (lat !== 10) begin
            failures++;
            $display("FAIL reset_op_latency got=%0d exp=10", lat);
        end
        checks++;
        if ({s_vbl, s_vsl, s_in1bl, s_in1sl, s_in1wl} !==
            {4'b1000, 4'b0100, 16'h00F0, 16'h00F0, 16'h0001}) begin
            failures++;
            $display("FAIL reset_op_lines got=%b/%b/%h/%h/%h",
                     s_vbl, s_vsl, s_in1bl, s_in1sl, s_in1wl);
        end
        checks++;
        if (tr_en !== 64'h03FC || tr_any !== 64'h03FC) begin
            failures++;
            $display("FAIL reset_op_pulse got=%h/%h exp=3fc/3fc", tr_en, tr_any);
        end
        g = sb.pop_front();
        checks++;
        if ({RSP_ERR, RSP_CSA, RSP_ADC} !== {g.err, g.csa, g.adc}) begin
            failures++;
            $display("FAIL reset_op_rsp got=%b/%h/%h exp=%b/%h/%h",
                     RSP_ERR, RSP_CSA, RSP_ADC, g.err, g.csa, g.adc);
        end
        ack();
    endtask

    task automatic test_zero_mask();
        exp_t e, g;
        e = '{err: 1'b1, csa: 16'h0, adc: 48'h0};
        run_op(2'd1, 4'd9, 16'h0000, 1'b0, 0, e);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL zero_mask_latency got=%0d exp=2", lat);
        end
        checks++;
        if (tr_any !== 64'h0) begin
            failures++;
            $display("FAIL zero_mask_enables got=%h exp=0", tr_any);
        end
        g = sb.pop_front();
        checks++;
        if ({RSP_ERR, RSP_CSA, RSP_ADC} !== {g.err, g.csa, g.adc}) begin
            failures++;
            $display("FAIL zero_mask_rsp got=%b/%h/%h exp=%b/%h/%h",
                     RSP_ERR, RSP_CSA, RSP_ADC, g.err, g.csa, g.adc);
        end
        ack();
    endtask

    task automatic test_abort();
        exp_t e, g;
        e = '{err: 1'b1, csa: 16'h0, adc: 48'h0};
        run_op(2'd0, 4'd2, 16'h0, 1'b0, 5, e);
        checks++;
        if (lat !== 6) begin
            failures++;
            $display("FAIL abort_latency got=%0d exp=6", lat);
        end
        checks++;
        if (tr_en !== 64'h0030 || tr_any !== 64'h003C) begin
            failures++;
            $display("FAIL abort_enables got=%h/%h exp=30/3c", tr_en, tr_any);
        end
        g = sb.pop_front();
        checks++;
        if ({RSP_ERR, RSP_CSA, RSP_ADC} !== {g.err, g.csa, g.adc}) begin
            failures++;
            $display("FAIL abort_rsp got=%b/%h/%h exp=%b/%h/%h",
                     RSP_ERR, RSP_CSA, RSP_ADC, g.err, g.csa, g.adc);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        exp_t e, g;
        e = '{err: 1'b0, csa: 16'h0, adc: 48'h0};
        run_op(2'd3, 4'd3, 16'h8001, 1'b0, 0, e);
        checks++;
        if (lat !== 10 || {s_vwl, s_vbl, s_vsl} !== {4'b0100, 4'b0010, 4'b1000}) begin
            failures++;
            $display("FAIL form_lat_bias got=%0d/%b/%b/%b exp=10/0100/0010/1000",
                     lat, s_vwl, s_vbl, s_vsl);
        end
        g = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({RSP_VALID, REQ_READY, RSP_ERR, RSP_CSA, RSP_ADC} !==
                {1'b1, 1'b0, g.err, g.csa, g.adc}) begin
                failures++;
                $display("FAIL hold_rsp cyc=%0d got=%b/%b/%b/%h/%h", i,
                         RSP_VALID, REQ_READY, RSP_ERR, RSP_CSA, RSP_ADC);
            end
            @(negedge CLK);
        end
        RSP_READY = 1'b1;
        run_op(2'd3, 4'd7, 16'h0F00, 1'b0, 0, e);
        checks++;
        if (wait_edges !== 2 || lat !== 10) begin
            failures++;
            $display("FAIL b2b_accept got=%0d/%0d exp=2/10", wait_edges, lat);
        end
        g = sb.pop_front();
        checks++;
        if ({RSP_ERR, RSP_CSA, RSP_ADC} !== {g.err, g.csa, g.adc}) begin
            failures++;
            $display("FAIL b2b_rsp got=%b/%h/%h exp=%b/%h/%h",
                     RSP_ERR, RSP_CSA, RSP_ADC, g.err, g.csa, g.adc);
        end
        ack();
    endtask

    task automatic test_async_reset();
        REQ_OP = 2'd1;
        REQ_ROW = 4'd1;
        REQ_COL_MASK = 16'hFFFF;
        REQ_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({ENABLE_WL, ENABLE_BL, ENABLE_SL} !== 3'b111) begin
            failures++;
            $display("FAIL pulse_active got=%b exp=111",
                     {ENABLE_WL, ENABLE_BL, ENABLE_SL});
        end
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (outs_nonzero() !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_drop got=%b/%b exp=0/0",
                     ENABLE_WL, outs_nonzero());
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (REQ_READY !== 1'b1 || outs_nonzero() !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_release got=%b/%b exp=1/0",
                     REQ_READY, outs_nonzero());
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_reset_op();
        test_zero_mask();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
